// File: rtl/fwd_scoreboard.sv
// Operand forwarding and load-use hazard unit beside the ID/EX register.
// A shift-register scoreboard tracks DEPTH in-flight writes; entry 0 is the youngest (EX/MEM).
module fwd_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1),
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_dest,
  input  logic                          issue_reg_write,
  input  logic                          issue_is_load,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_reg,
  input  logic [NUM_SRC-1:0]            src_used,
  input  logic                          flush,
  output logic [NUM_SRC*SEL_W-1:0]      forward_sel,
  output logic                          stall,
  output logic [CNT_W-1:0]              stall_count
);

  logic [DEPTH-1:0]      v_q, v_d;
  logic [DEPTH-1:0]      wr_q, wr_d;
  logic [DEPTH-1:0]      ld_q, ld_d;
  logic [REG_ADDR_W-1:0] dest_q [DEPTH];
  logic [REG_ADDR_W-1:0] dest_d [DEPTH];
  logic [DEPTH-1:0]      ready;
  logic [NUM_SRC-1:0]    hazard;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Load data only becomes forwardable once it has reached entry LOAD_READY.
  generate
    for (genvar gk = 0; gk < DEPTH; gk++) begin : g_ready
      localparam bit LOAD_STAGE_OK = (gk >= LOAD_READY);
      assign ready[gk] = !ld_q[gk] || LOAD_STAGE_OK;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_ADDR_W-1:0] src;
      logic [DEPTH-1:0]      match;
      logic [SEL_W-1:0]      sel;
      logic                  haz;
      logic                  found;

      assign src = src_reg[gi*REG_ADDR_W +: REG_ADDR_W];

      for (genvar gk = 0; gk < DEPTH; gk++) begin : g_match
        assign match[gk] = v_q[gk] && wr_q[gk] && src_used[gi] &&
                           (dest_q[gk] == src) && (dest_q[gk] != '0);
      end

      // Youngest match decides alone, so an unready young load blocks older ready data.
      always_comb begin
        sel   = '0;
        haz   = 1'b0;
        found = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
          if (!found && match[k]) begin
            found = 1'b1;
            if (ready[k]) begin
              sel = SEL_W'(k + 1);
            end else begin
              haz = 1'b1;
            end
          end
        end
      end

      assign forward_sel[gi*SEL_W +: SEL_W] = sel;
      assign hazard[gi]                     = haz;
    end
  endgenerate

  assign stall = issue_valid && !flush && (|hazard);

  // A stalled or flushed consumer enters the scoreboard as a bubble.
  always_comb begin
    v_d[0]    = issue_valid && !stall && !flush;
    wr_d[0]   = issue_reg_write;
    ld_d[0]   = issue_is_load;
    dest_d[0] = issue_dest;
  end

  generate
    for (genvar gk = 1; gk < DEPTH; gk++) begin : g_shift
      always_comb begin
        v_d[gk]    = v_q[gk-1];
        wr_d[gk]   = wr_q[gk-1];
        ld_d[gk]   = ld_q[gk-1];
        dest_d[gk] = dest_q[gk-1];
      end
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      wr_q  <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      wr_q  <= wr_d;
      ld_q  <= ld_d;
      cnt_q <= cnt_d;
    end
  end

  // Destination tags are qualified by v, so they need no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      dest_q[k] <= dest_d[k];
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: each step pushes expected outputs to a queue,
// then pops and checks them against the combinational outputs mid-cycle.
module tb_fwd_scoreboard;

  localparam int RW    = 5;
  localparam int NS    = 2;
  localparam int SW    = 2;
  localparam int CW    = 4;

  logic             clk;
  logic             rst;
  logic             issue_valid;
  logic [RW-1:0]    issue_dest;
  logic             issue_reg_write;
  logic             issue_is_load;
  logic [NS*RW-1:0] src_reg;
  logic [NS-1:0]    src_used;
  logic             flush;
  logic [NS*SW-1:0] forward_sel;
  logic             stall;
  logic [CW-1:0]    stall_count;

  fwd_scoreboard #(
    .REG_ADDR_W(RW), .NUM_SRC(NS), .DEPTH(3), .LOAD_READY(1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_reg_write(issue_reg_write), .issue_is_load(issue_is_load),
    .src_reg(src_reg), .src_used(src_used), .flush(flush),
    .forward_sel(forward_sel), .stall(stall), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    s0;
    logic [1:0]    s1;
    logic          st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  int            total;
  int            bad;
  logic [CW-1:0] exp_cnt;

  task automatic step(input string tag, input logic rs, input logic iv,
                      input logic [RW-1:0] dst, input logic w, input logic l,
                      input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                      input logic [1:0] used, input logic fl,
                      input logic [1:0] e0, input logic [1:0] e1, input logic es);
    exp_t e;
    @(negedge clk);
    rst             = rs;
    issue_valid     = iv;
    issue_dest      = dst;
    issue_reg_write = w;
    issue_is_load   = l;
    src_reg         = {s1, s0};
    src_used        = used;
    flush           = fl;
    exp_q.push_back('{s0: e0, s1: e1, st: es, cnt: exp_cnt});
    #1;
    e = exp_q.pop_front();
    total++;
    assert (forward_sel[1:0] === e.s0) else begin
      bad++;
      $error("FAIL %s sel0 got=%0d want=%0d", tag, forward_sel[1:0], e.s0);
    end
    total++;
    assert (forward_sel[3:2] === e.s1) else begin
      bad++;
      $error("FAIL %s sel1 got=%0d want=%0d", tag, forward_sel[3:2], e.s1);
    end
    total++;
    assert (stall === e.st) else begin
      bad++;
      $error("FAIL %s stall got=%0b want=%0b", tag, stall, e.st);
    end
    total++;
    assert (stall_count === e.cnt) else begin
      bad++;
      $error("FAIL %s stall_count got=%0d want=%0d", tag, stall_count, e.cnt);
    end
    $display("step %-20s sel0=%0d sel1=%0d stall=%0b cnt=%0d", tag,
             forward_sel[1:0], forward_sel[3:2], stall, stall_count);
    if (rs) exp_cnt = '0;
    else if (es && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    exp_cnt = '0;
    rst = 1'b1;
    issue_valid = 1'b0;
    issue_dest = '0;
    issue_reg_write = 1'b0;
    issue_is_load = 1'b0;
    src_reg = '0;
    src_used = '0;
    flush = 1'b0;
    repeat (2) @(negedge clk);

    //   tag                   rs iv dst w  l  s0  s1  used   fl sel0 sel1 stall
    step("reset_state",        0, 0, 0,  0, 0, 0,  0,  2'b00, 0, 0, 0, 0);
    step("add_r3",             0, 1, 3,  1, 0, 0,  0,  2'b00, 0, 0, 0, 0);
    step("alu_fwd_e0",         0, 1, 10, 1, 0, 3,  3,  2'b11, 0, 1, 1, 0);
    step("alu_fwd_e1",         0, 1, 11, 0, 0, 3,  3,  2'b11, 0, 2, 2, 0);
    step("alu_fwd_e2",         0, 1, 12, 0, 0, 3,  3,  2'b11, 0, 3, 3, 0);
    step("r3_retired",         0, 0, 0,  0, 0, 3,  10, 2'b11, 0, 0, 3, 0);
    step("lw_r5",              0, 1, 5,  1, 1, 0,  0,  2'b00, 0, 0, 0, 0);
    step("load_use_stall",     0, 1, 6,  1, 0, 5,  0,  2'b01, 0, 0, 0, 1);
    step("load_use_fwd",       0, 1, 6,  1, 0, 5,  0,  2'b01, 0, 2, 0, 0);
    step("add_r7_a",           0, 1, 7,  1, 0, 0,  0,  2'b00, 0, 0, 0, 0);
    step("add_r7_b",           0, 1, 7,  1, 0, 0,  0,  2'b00, 0, 0, 0, 0);
    step("youngest_alu",       0, 1, 20, 0, 0, 7,  6,  2'b11, 0, 1, 3, 0);
    step("add_r7_c",           0, 1, 7,  1, 0, 0,  0,  2'b00, 0, 0, 0, 0);
    step("lw_r7",              0, 1, 7,  1, 1, 0,  0,  2'b00, 0, 0, 0, 0);
    step("youngest_load",      0, 1, 21, 0, 0, 7,  7,  2'b11, 0, 0, 0, 1);
    step("youngest_load_fwd",  0, 1, 21, 0, 0, 7,  7,  2'b11, 0, 2, 2, 0);
    step("add_r0",             0, 1, 0,  1, 0, 0,  0,  2'b00, 0, 0, 0, 0);
    step("lw_r0_read_r0",      0, 1, 0,  1, 1, 0,  0,  2'b11, 0, 0, 0, 0);
    step("read_r0_add_r4",     0, 1, 4,  1, 0, 0,  0,  2'b11, 0, 0, 0, 0);
    step("src_used_mask",      0, 0, 0,  0, 0, 4,  4,  2'b10, 0, 0, 1, 0);
    step("lw_r9",              0, 1, 9,  1, 1, 4,  0,  2'b00, 0, 0, 0, 0);
    step("flush_stall",        0, 1, 11, 1, 0, 9,  0,  2'b01, 1, 0, 0, 0);
    step("flushed_not_fwd",    0, 0, 0,  0, 0, 11, 9,  2'b11, 0, 0, 2, 0);
    step("lw_r12",             0, 1, 12, 1, 1, 0,  0,  2'b00, 0, 0, 0, 0);
    step("hazard_no_issue",    0, 0, 0,  0, 0, 12, 12, 2'b11, 0, 0, 0, 0);
    step("lw_r13",             0, 1, 13, 1, 1, 0,  0,  2'b00, 0, 0, 0, 0);
    step("rst_during_stall",   1, 1, 14, 1, 0, 13, 0,  2'b01, 0, 0, 0, 1);
    step("after_reset",        0, 1, 14, 0, 0, 13, 0,  2'b01, 0, 0, 0, 0);

    for (int n = 0; n < 20; n++) begin
      step("sat_lw",           0, 1, 5,  1, 1, 0,  0,  2'b00, 0, 0, 0, 0);
      step("sat_use",          0, 1, 6,  0, 0, 5,  0,  2'b01, 0, 0, 0, 1);
    end
    step("sat_hold",           0, 0, 0,  0, 0, 0,  0,  2'b00, 0, 0, 0, 0);

    total++;
    assert (stall_count === 4'd15) else begin
      bad++;
      $error("FAIL saturated_count got=%0d want=15", stall_count);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the two-stage EX/MEM, MEM/WB forwarding unit.
- Keeps an internal shift-register scoreboard of in-flight register writes across DEPTH post-issue stages.
- Generates per-source forward selects for NUM_SRC operands and detects load-use hazards, with a stall request and a saturating stall counter.
- Sits beside the ID/EX register. Consumer = instruction currently in ID/EX.

Parameters:
- REG_ADDR_W, 5, register address width; register 0 is hard-wired zero and never forwarded.
- NUM_SRC, 2, number of source operands per consumer.
- DEPTH, 3, tracked stages after issue. Entry 0 = EX/MEM, entry 1 = MEM/WB, entry 2 = WB/commit.
- LOAD_READY, 1, lowest entry index at which load data is forwardable. Legal range 0..DEPTH-1.
- SEL_W, $clog2(DEPTH+1), forward select width (derived).
- CNT_W, 16, stall counter width.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- issue_valid, input, 1, consumer in ID/EX is valid.
- issue_dest, input, REG_ADDR_W, consumer destination register.
- issue_reg_write, input, 1, consumer writes issue_dest.
- issue_is_load, input, 1, consumer result is produced by memory.
- src_reg, input, NUM_SRC*REG_ADDR_W, consumer source registers; operand i at bits [i*REG_ADDR_W +: REG_ADDR_W].
- src_used, input, NUM_SRC, operand i is actually read.
- flush, input, 1, kill consumer this cycle.
- forward_sel, output, NUM_SRC*SEL_W, per-operand select: 0 = register file, k+1 = entry k.
- stall, output, 1, hold ID/EX and earlier stages; insert bubble.
- stall_count, output, CNT_W, saturating count of stalled cycles.

Behaviour:
- State per entry k:
  - v[k], dest[k], wr[k], ld[k].
- Reset:
  - All v=0, stall_count=0.
  - Hence forward_sel=0 and stall=0 in the cycle after reset.
  - Reset mid-stall clears everything; no stall is carried over.
- match(i,k) = v[k] & wr[k] & src_used[i] & (dest[k]==src_reg_i) & (dest[k]!=0).
- ready(k) = !ld[k] | (k >= LOAD_READY).
- Per operand i, the youngest matching entry m (lowest k) decides:
  - No match: sel_i = 0.
  - Match and ready(m): sel_i = m+1.
  - Match and !ready(m): sel_i = 0 and hazard_i = 1.
  - An older ready match never overrides a younger unready one.
- stall = issue_valid & !flush & OR(hazard_i).
- forward_sel and stall are purely combinational from state and inputs; zero-cycle latency.
- Every cycle the scoreboard shifts: entry k <= entry k-1 for k = 1..DEPTH-1. The oldest entry drops out.
- Entry 0 load:
  - If issue_valid & !stall & !flush: v[0] <= 1, with dest/wr/ld taken from the issue_* inputs.
  - Otherwise v[0] <= 0 (bubble).
- A stall therefore self-clears once the load reaches entry LOAD_READY.
  - Stall length = LOAD_READY - m cycles; default is 1 cycle for load-use.
- flush has priority over stall. A flushed consumer is never recorded.
- stall_count increments by 1 on each cycle with stall=1 and saturates at all-ones (no wrap).
- Only rst clears stall_count; flush does not.
- The same source register on multiple operands yields identical selects.
- Operands with src_used=0 always get sel=0 and never raise a hazard.

Test Plan:
- ALU-to-ALU forwarding:
  - Issue ADD r3 (non-load), next cycle issue a consumer with src0=r3, src1=r3 → forward_sel = {2'd1, 2'd1}, stall=0.
  - Two cycles later, issue a consumer of r3 → sel=3 from entry 2.
- Load-use stall:
  - Issue LW r5, then a consumer with src0=r5 → stall=1 for exactly 1 cycle with sel0=0.
  - Next cycle stall=0, sel0=2; stall_count=1.
- Youngest-wins priority:
  - Entry 1 writes r7 (ALU), entry 0 writes r7 (ALU), consumer reads r7 → sel=1, not 2.
  - Repeat with entry 0 as a load → stall=1, even though entry 1 is ready.
- r0 and src_used masking:
  - Producer with dest=r0 and reg_write=1, consumer reads r0 → sel=0, stall=0.
  - Producer r4 with consumer src_used=0 on r4 → sel=0.
- Flush and reset mid-operation:
  - During a load-use stall, assert flush → stall=0 that cycle and entry 0 becomes a bubble; the flushed instruction is never forwarded.
  - Assert rst during a stall → next cycle all sel=0, stall=0, stall_count=0.
- Counter saturation:
  - With CNT_W=4, hold a hazard across 20 stalled cycles (repeatedly re-create the load-use case) → stall_count stops at 15.
